// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between instruction fetch
// and data memory ports. Data accesses win, but fetch is forced through after
// MAX_DM_STREAK consecutive data grants while a fetch is waiting.
module unified_mem_arbiter #(
  parameter int ADDR_W        = 7,
  parameter int DATA_W        = 32,
  parameter int RD_LAT        = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_req,
  input  logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_rdata,
  output logic              im_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [1:0]        grant
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam int STK_W = $clog2(MAX_DM_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state;
  logic               owner_dm;
  logic               is_write;
  logic [CNT_W-1:0]   wait_cnt;
  logic [STK_W-1:0]   streak;
  logic               pick_dm;
  logic               streak_full;

  // Grant decision for the IDLE state: DM unless fetch has been starved too long
  always_comb begin
    streak_full = (streak == STK_W'(MAX_DM_STREAK));
    pick_dm     = dm_req && !(im_req && streak_full);
  end

  // Access sequencer: IDLE -> ISSUE -> WAIT (RD_LAT cycles) -> DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner_dm <= 1'b0;
      is_write <= 1'b0;
      wait_cnt <= '0;
      streak   <= '0;
      im_rdata <= '0;
      dm_rdata <= '0;
      im_done  <= 1'b0;
      dm_done  <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      grant    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (im_req || dm_req) begin
            owner_dm <= pick_dm;
            mem_en   <= 1'b1;
            state    <= ISSUE;
            if (pick_dm) begin
              mem_addr <= dm_addr;
              mem_din  <= dm_wdata;
              mem_we   <= dm_we;
              is_write <= dm_we;
              grant    <= 2'b10;
              if (!im_req)
                streak <= '0;
              else if (!streak_full)
                streak <= streak + STK_W'(1);
            end else begin
              mem_addr <= im_addr;
              mem_we   <= 1'b0;
              is_write <= 1'b0;
              grant    <= 2'b01;
              streak   <= '0;
            end
          end
        end
        ISSUE: begin
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          wait_cnt <= CNT_W'(RD_LAT);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == CNT_W'(1)) begin
            if (!is_write) begin
              if (owner_dm) dm_rdata <= mem_dout;
              else          im_rdata <= mem_dout;
            end
            if (owner_dm) dm_done <= 1'b1;
            else          im_done <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          im_done <= 1'b0;
          dm_done <= 1'b0;
          grant   <= 2'b00;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: RD_LAT=1 instance for the main scenarios, RD_LAT=3 instance
// for the long-latency load. RAM models drive read data only in the cycle it
// becomes valid, so early or late capture reads back zero.
module tb_unified_mem_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // RD_LAT=1 instance
  logic          im_req, dm_req, dm_we, im_done, dm_done, mem_en, mem_we;
  logic [AW-1:0] im_addr, dm_addr, mem_addr;
  logic [DW-1:0] dm_wdata, im_rdata, dm_rdata, mem_din, mem_dout;
  logic [1:0]    grant;

  // RD_LAT=3 instance
  logic          im_req1, dm_req1, dm_we1, im_done1, dm_done1, mem_en1, mem_we1;
  logic [AW-1:0] im_addr1, dm_addr1, mem_addr1;
  logic [DW-1:0] dm_wdata1, im_rdata1, dm_rdata1, mem_din1, mem_dout1;
  logic [1:0]    grant1;

  // RAM preload port
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_DM_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_done(im_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .grant(grant)
  );

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .MAX_DM_STREAK(4)) dut_lat3 (
    .clk(clk), .rst(rst),
    .im_req(im_req1), .im_addr(im_addr1), .im_rdata(im_rdata1), .im_done(im_done1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_done(dm_done1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_din(mem_din1),
    .mem_dout(mem_dout1), .grant(grant1)
  );

  // RAM model, latency 1: read data present only in the cycle after the enable
  logic [DW-1:0] ram0 [128];
  always @(posedge clk) begin
    if (pl_en) ram0[pl_addr] <= pl_data;
    else if (mem_en && mem_we) ram0[mem_addr] <= mem_din;
    mem_dout <= (mem_en && !mem_we) ? ram0[mem_addr] : '0;
  end

  // RAM model, latency 3: two extra pipeline stages after the array read
  logic [DW-1:0] ram1 [128];
  logic [DW-1:0] p1a, p1b;
  always @(posedge clk) begin
    if (pl_en) ram1[pl_addr] <= pl_data;
    else if (mem_en1 && mem_we1) ram1[mem_addr1] <= mem_din1;
    p1a       <= (mem_en1 && !mem_we1) ? ram1[mem_addr1] : '0;
    p1b       <= p1a;
    mem_dout1 <= p1b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    im_req = 1'b0; dm_req = 1'b0; dm_req1 = 1'b0;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  initial begin
    string seq;
    string exp_seq;
    int    n;
    bit    both, bad_grant, stray_done;

    im_req = 1'b0; im_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    im_req1 = 1'b0; im_addr1 = '0; dm_req1 = 1'b0; dm_we1 = 1'b0; dm_addr1 = '0; dm_wdata1 = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    p1a = '0; p1b = '0;

    cyc(); cyc();
    pl_en = 1'b1; pl_addr = 7'h05; pl_data = 32'hDEADBEEF; cyc();
    pl_addr = 7'h20; pl_data = 32'hA5A50003; cyc();
    pl_en = 1'b0;

    check("rst_grant", {30'd0, grant}, 0);
    check("rst_mem_en", {31'd0, mem_en}, 0);
    check("rst_mem_addr", {25'd0, mem_addr}, 0);
    check("rst_dones", {30'd0, im_done, dm_done}, 0);
    check("rst_rdata", im_rdata | dm_rdata, 0);

    // IM-only read on the RD_LAT=1 instance, DM load on the RD_LAT=3 instance
    rst = 1'b0;
    im_req = 1'b1; im_addr = 7'h05;
    dm_req1 = 1'b1; dm_we1 = 1'b0; dm_addr1 = 7'h20;
    cyc(); // cycle 1
    check("im_c1_en", {31'd0, mem_en}, 1);
    check("im_c1_addr", {25'd0, mem_addr}, 32'h05);
    check("im_c1_grant", {30'd0, grant}, 32'h1);
    check("lat3_c1_en", {31'd0, mem_en1}, 1);
    cyc(); // cycle 2
    check("im_c2_grant", {30'd0, grant}, 32'h1);
    check("im_c2_en", {31'd0, mem_en}, 0);
    check("im_c2_done", {31'd0, im_done}, 0);
    cyc(); // cycle 3
    check("im_c3_done", {31'd0, im_done}, 1);
    check("im_c3_rdata", im_rdata, 32'hDEADBEEF);
    check("im_c3_grant", {30'd0, grant}, 32'h1);
    check("lat3_c3_done", {31'd0, dm_done1}, 0);
    im_req = 1'b0;
    cyc(); // cycle 4
    check("im_c4_done", {31'd0, im_done}, 0);
    check("im_c4_grant", {30'd0, grant}, 0);
    check("lat3_c4_done", {31'd0, dm_done1}, 0);
    cyc(); // cycle 5
    check("lat3_c5_done", {31'd0, dm_done1}, 1);
    check("lat3_c5_rdata", dm_rdata1, 32'hA5A50003);
    check("lat3_im_rdata", im_rdata1, 0);
    dm_req1 = 1'b0;

    // DM store 0x12345678 -> 0x10
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 7'h10; dm_wdata = 32'h12345678;
    cyc();
    check("st_c1_we", {31'd0, mem_we}, 1);
    check("st_c1_din", mem_din, 32'h12345678);
    check("st_c1_grant", {30'd0, grant}, 32'h2);
    cyc();
    check("st_c2_we", {31'd0, mem_we}, 0);
    check("st_c2_addr_hold", {25'd0, mem_addr}, 32'h10);
    cyc();
    check("st_c3_done", {31'd0, dm_done}, 1);
    check("st_c3_rdata", dm_rdata, 0);
    check("st_c3_im_done", {31'd0, im_done}, 0);
    dm_req = 1'b0; dm_we = 1'b0;
    cyc();
    // DM load of 0x10
    dm_req = 1'b1;
    cyc(); cyc(); cyc();
    check("ld_c3_done", {31'd0, dm_done}, 1);
    check("ld_c3_rdata", dm_rdata, 32'h12345678);
    check("ld_im_rdata_kept", im_rdata, 32'hDEADBEEF);
    dm_req = 1'b0;
    cyc();

    // Simultaneous requests, streak=0: DM first, IM on the next IDLE
    do_reset();
    im_req = 1'b1; im_addr = 7'h05; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 7'h10;
    cyc();
    check("sim_c1_grant", {30'd0, grant}, 32'h2);
    cyc(); cyc();
    check("sim_c3_dones", {30'd0, im_done, dm_done}, 32'h1);
    check("sim_c3_rdata", dm_rdata, 32'h12345678);
    dm_req = 1'b0;
    cyc(); cyc();
    check("sim_c5_grant", {30'd0, grant}, 32'h1);
    cyc(); cyc();
    check("sim_c7_dones", {30'd0, im_done, dm_done}, 32'h2);
    check("sim_c7_rdata", im_rdata, 32'hDEADBEEF);
    im_req = 1'b0;
    cyc();

    // Starvation: both held continuously
    do_reset();
    seq = ""; n = 0; both = 1'b0; bad_grant = 1'b0;
    exp_seq = "DDDDIDDDDID";
    im_req = 1'b1; im_addr = 7'h05; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 7'h10;
    for (int k = 0; k < 80 && n < 11; k++) begin
      cyc();
      if (im_done && dm_done) both = 1'b1;
      if (grant == 2'b11) bad_grant = 1'b1;
      if (dm_done) begin seq = {seq, "D"}; n++; end
      else if (im_done) begin seq = {seq, "I"}; n++; end
    end
    im_req = 1'b0; dm_req = 1'b0;
    check("starve_count", n, 11);
    check("starve_both_done", {31'd0, both}, 0);
    check("starve_grant11", {31'd0, bad_grant}, 0);
    for (int i = 0; i < 11; i++) begin
      byte got_c, exp_c;
      got_c = (i < seq.len()) ? seq[i] : 8'h00;
      exp_c = exp_seq[i];
      check($sformatf("starve_seq%0d", i), {24'd0, got_c}, {24'd0, exp_c});
    end

    // Reset during WAIT of an IM read
    do_reset();
    im_req = 1'b1; im_addr = 7'h05;
    cyc(); cyc(); // cycle 2 = WAIT
    rst = 1'b1; im_req = 1'b0;
    cyc();
    check("rw_grant", {30'd0, grant}, 0);
    check("rw_mem", {23'd0, mem_en, mem_we, mem_addr}, 0);
    check("rw_dones", {30'd0, im_done, dm_done}, 0);
    check("rw_rdata", im_rdata | dm_rdata | mem_din, 0);
    rst = 1'b0;
    stray_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (im_done || dm_done) stray_done = 1'b1;
    end
    check("rw_no_done", {31'd0, stray_done}, 0);
    im_req = 1'b1;
    cyc(); cyc(); cyc();
    check("rw_fresh_done", {31'd0, im_done}, 1);
    check("rw_fresh_rdata", im_rdata, 32'hDEADBEEF);
    im_req = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
